// File: rtl/shift_issue.sv
// Shift-instruction issue stage: decodes RISC-V shifts, captures operands with
// writeback bypass, and holds them in a 2-entry in-order skid buffer.
//
// state | meaning
// EMPTY | no entries held, out_valid low
// ONE   | head entry valid, can still accept
// FULL  | both entries valid, in_ready low
module shift_issue #(
  parameter int XLEN = 32
) (
  input  logic            CLK,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [6:0]      opcode,
  input  logic [2:0]      funct3,
  input  logic [6:0]      funct7,
  input  logic [11:0]     imm,
  input  logic [4:0]      rs1_addr,
  input  logic [4:0]      rs2_addr,
  input  logic [4:0]      rd_addr,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic            fwd_valid,
  input  logic [4:0]      fwd_rd,
  input  logic [XLEN-1:0] fwd_data,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] Src1,
  output logic [4:0]      Src2,
  output logic            funct3_2,
  output logic            funct7_5,
  output logic            En,
  output logic [4:0]      rd_out,
  output logic            illegal
);

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

  typedef struct packed {
    logic [XLEN-1:0] src1;
    logic [4:0]      src2;
    logic            f3_2;
    logic            f7_5;
    logic            en;
    logic [4:0]      rd;
    logic            illegal;
  } entry_t;

  state_t state, state_nxt;
  entry_t head, tail, new_entry;

  logic accept, pop;
  logic ld_head, ld_tail, advance, clr;

  logic       is_opimm, is_op, is_shift, legal;
  logic [6:0] f7;
  logic       fwd_rs1, fwd_rs2;
  logic [4:0] rs2_low;
  logic       unused_rs2_hi;

  // Decode
  assign is_opimm = (opcode == 7'b0010011);
  assign is_op    = (opcode == 7'b0110011);
  assign f7       = is_opimm ? imm[11:5] : funct7;
  assign is_shift = (is_opimm || is_op) && ((funct3 == 3'b001) || (funct3 == 3'b101));
  assign legal    = ((funct3 == 3'b001) && (f7 == 7'b0000000)) ||
                    ((funct3 == 3'b101) && ((f7 == 7'b0000000) || (f7 == 7'b0100000)));

  // Bypass is applied only here, at capture; held entries keep captured values
  assign fwd_rs1 = fwd_valid && (fwd_rd == rs1_addr) && (rs1_addr != 5'd0);
  assign fwd_rs2 = fwd_valid && (fwd_rd == rs2_addr) && (rs2_addr != 5'd0);
  assign rs2_low = fwd_rs2 ? fwd_data[4:0] : rs2_data[4:0];
  assign unused_rs2_hi = ^rs2_data[XLEN-1:5];

  always_comb begin
    new_entry         = '0;
    new_entry.src1    = fwd_rs1 ? fwd_data : rs1_data;
    new_entry.src2    = is_opimm ? imm[4:0] : rs2_low;
    new_entry.f3_2    = funct3[2];
    new_entry.f7_5    = f7[5];
    new_entry.en      = is_shift && legal;
    new_entry.illegal = is_shift && !legal;
    new_entry.rd      = rd_addr;
  end

  // Handshakes
  assign in_ready  = (state != FULL) && !rst;
  assign out_valid = (state != EMPTY) && !rst;
  assign accept    = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready;

  always_comb begin
    state_nxt = state;
    ld_head   = 1'b0;
    ld_tail   = 1'b0;
    advance   = 1'b0;
    clr       = 1'b0;
    if (flush) begin
      state_nxt = EMPTY;
      clr       = 1'b1;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            state_nxt = ONE;
            ld_head   = 1'b1;
          end
        end
        ONE: begin
          if (accept && pop) begin
            ld_head = 1'b1;
          end else if (accept) begin
            state_nxt = FULL;
            ld_tail   = 1'b1;
          end else if (pop) begin
            state_nxt = EMPTY;
            clr       = 1'b1;
          end
        end
        FULL: begin
          if (pop) begin
            state_nxt = ONE;
            advance   = 1'b1;
          end
        end
        default: begin
          state_nxt = EMPTY;
          clr       = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (rst) begin
      state <= EMPTY;
      head  <= '0;
      tail  <= '0;
    end else begin
      state <= state_nxt;
      if (clr) begin
        head <= '0;
        tail <= '0;
      end else if (advance) begin
        head <= tail;
        tail <= '0;
      end else begin
        if (ld_head) head <= new_entry;
        if (ld_tail) tail <= new_entry;
      end
    end
  end

  // Outputs forced to zero whenever nothing is presented
  assign Src1     = out_valid ? head.src1    : '0;
  assign Src2     = out_valid ? head.src2    : '0;
  assign funct3_2 = out_valid ? head.f3_2    : 1'b0;
  assign funct7_5 = out_valid ? head.f7_5    : 1'b0;
  assign En       = out_valid ? head.en      : 1'b0;
  assign rd_out   = out_valid ? head.rd      : '0;
  assign illegal  = out_valid ? head.illegal : 1'b0;

endmodule

// File: tb/tb_shift_issue.sv
// Directed self-checking bench for shift_issue: decode, bypass, skid buffer
// ordering, flush and reset behaviour.
module tb_shift_issue;

  localparam int XLEN = 32;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] OP_REG = 7'b0110011;

  logic            CLK = 1'b0;
  logic            rst, in_valid, in_ready;
  logic [6:0]      opcode, funct7;
  logic [2:0]      funct3;
  logic [11:0]     imm;
  logic [4:0]      rs1_addr, rs2_addr, rd_addr, fwd_rd;
  logic [XLEN-1:0] rs1_data, rs2_data, fwd_data;
  logic            fwd_valid, flush, out_valid, out_ready;
  logic [XLEN-1:0] Src1;
  logic [4:0]      Src2, rd_out;
  logic            funct3_2, funct7_5, En, illegal;

  int n_chk  = 0;
  int n_pass = 0;

  shift_issue #(.XLEN(XLEN)) dut (
    .CLK(CLK), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .funct3(funct3), .funct7(funct7), .imm(imm),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rd_addr(rd_addr),
    .rs1_data(rs1_data), .rs2_data(rs2_data),
    .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .Src1(Src1), .Src2(Src2), .funct3_2(funct3_2), .funct7_5(funct7_5),
    .En(En), .rd_out(rd_out), .illegal(illegal)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                       input logic [11:0] im, input logic [4:0] a1, input logic [4:0] a2,
                       input logic [4:0] rd, input logic [XLEN-1:0] d1, input logic [XLEN-1:0] d2);
    in_valid = 1'b1;
    opcode = op; funct3 = f3; funct7 = f7; imm = im;
    rs1_addr = a1; rs2_addr = a2; rd_addr = rd;
    rs1_data = d1; rs2_data = d2;
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, ".out_valid"}, 64'(out_valid), 64'd0);
    chk({tag, ".Src1"},      64'(Src1),      64'd0);
    chk({tag, ".rest"},      64'({Src2, funct3_2, funct7_5, En, rd_out, illegal}), 64'd0);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
    fwd_valid = 1'b0; fwd_rd = '0; fwd_data = '0;
    drive(OP_IMM, 3'b001, 7'd0, 12'd0, 5'd0, 5'd0, 5'd0, '0, '0);
    in_valid = 1'b0;

    // Reset
    step(); step();
    chk("rst.in_ready", 64'(in_ready), 64'd0);
    check_zero_outputs("rst");
    rst = 1'b0;
    #1;
    chk("post_rst.in_ready", 64'(in_ready), 64'd1);
    chk("post_rst.out_valid", 64'(out_valid), 64'd0);

    // SLLI x5,x1,3
    out_ready = 1'b1;
    drive(OP_IMM, 3'b001, 7'd0, 12'h003, 5'd1, 5'd0, 5'd5, 32'h0000_00F0, 32'd0);
    step();
    in_valid = 1'b0;
    chk("slli.out_valid", 64'(out_valid), 64'd1);
    chk("slli.Src1", 64'(Src1), 64'hF0);
    chk("slli.Src2", 64'(Src2), 64'd3);
    chk("slli.flags", 64'({funct3_2, funct7_5, En, illegal}), 64'b0010);
    chk("slli.rd_out", 64'(rd_out), 64'd5);
    step();
    check_zero_outputs("slli_drain");

    // SRA with rs2 bypass; held entry must not re-forward
    out_ready = 1'b0;
    fwd_valid = 1'b1; fwd_rd = 5'd2; fwd_data = 32'h24;
    drive(OP_REG, 3'b101, 7'h20, 12'd0, 5'd3, 5'd2, 5'd7, 32'h8000_0000, 32'h1);
    step();
    in_valid = 1'b0;
    fwd_data = 32'h1F;
    chk("sra.Src2", 64'(Src2), 64'd4);
    chk("sra.Src1", 64'(Src1), 64'h8000_0000);
    chk("sra.flags", 64'({funct3_2, funct7_5, En, illegal}), 64'b1110);
    step();
    chk("sra_hold.Src2", 64'(Src2), 64'd4);
    chk("sra_hold.rd_out", 64'(rd_out), 64'd7);
    out_ready = 1'b1;
    step();
    chk("sra_drain.out_valid", 64'(out_valid), 64'd0);

    // SRLI imm=0x420 illegal; rs1 bypass
    fwd_rd = 5'd1; fwd_data = 32'h0000_ABCD;
    drive(OP_IMM, 3'b101, 7'd0, 12'h420, 5'd1, 5'd0, 5'd9, 32'h1111, 32'd0);
    step();
    in_valid = 1'b0; fwd_valid = 1'b0;
    chk("srli_bad.out_valid", 64'(out_valid), 64'd1);
    chk("srli_bad.flags", 64'({En, illegal}), 64'b01);
    chk("srli_bad.Src1", 64'(Src1), 64'hABCD);

    // SLLI with f7=0100000 is illegal; ADDI is a bubble (back-to-back, pops)
    drive(OP_IMM, 3'b001, 7'd0, 12'h403, 5'd4, 5'd0, 5'd6, 32'h5, 32'd0);
    step();
    chk("slli_bad.flags", 64'({En, illegal}), 64'b01);
    chk("slli_bad.rd_out", 64'(rd_out), 64'd6);
    drive(OP_IMM, 3'b000, 7'd0, 12'h005, 5'd4, 5'd0, 5'd8, 32'h5, 32'd0);
    step();
    in_valid = 1'b0;
    chk("addi.out_valid", 64'(out_valid), 64'd1);
    chk("addi.flags", 64'({En, illegal}), 64'b00);
    chk("addi.rd_out", 64'(rd_out), 64'd8);
    step();
    chk("addi_drain.out_valid", 64'(out_valid), 64'd0);

    // Backpressure: three shifts with out_ready low
    out_ready = 1'b0;
    drive(OP_IMM, 3'b001, 7'd0, 12'h001, 5'd1, 5'd0, 5'd10, 32'hA, 32'd0);
    chk("bp.a_ready", 64'(in_ready), 64'd1);
    step();
    drive(OP_IMM, 3'b001, 7'd0, 12'h002, 5'd1, 5'd0, 5'd11, 32'hB, 32'd0);
    chk("bp.b_ready", 64'(in_ready), 64'd1);
    step();
    drive(OP_IMM, 3'b001, 7'd0, 12'h003, 5'd1, 5'd0, 5'd12, 32'hC, 32'd0);
    chk("bp.full_ready", 64'(in_ready), 64'd0);
    step();
    chk("bp.full_ready2", 64'(in_ready), 64'd0);
    chk("bp.head_rd", 64'(rd_out), 64'd10);
    out_ready = 1'b1;
    step();
    chk("bp.second_rd", 64'(rd_out), 64'd11);
    chk("bp.second_src2", 64'(Src2), 64'd2);
    chk("bp.one_ready", 64'(in_ready), 64'd1);
    step();
    in_valid = 1'b0;
    chk("bp.third_rd", 64'(rd_out), 64'd12);
    chk("bp.third_src1", 64'(Src1), 64'hC);
    step();
    chk("bp.drain", 64'(out_valid), 64'd0);

    // Flush from FULL with a same-cycle input
    out_ready = 1'b0;
    drive(OP_IMM, 3'b001, 7'd0, 12'h001, 5'd1, 5'd0, 5'd13, 32'h1, 32'd0);
    step();
    drive(OP_IMM, 3'b001, 7'd0, 12'h001, 5'd1, 5'd0, 5'd14, 32'h2, 32'd0);
    step();
    chk("fl.full_ready", 64'(in_ready), 64'd0);
    drive(OP_IMM, 3'b001, 7'd0, 12'h001, 5'd1, 5'd0, 5'd15, 32'h3, 32'd0);
    flush = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    chk("fl.out_valid", 64'(out_valid), 64'd0);
    chk("fl.in_ready", 64'(in_ready), 64'd1);
    step();
    check_zero_outputs("fl_after");

    // Reset while ONE
    out_ready = 1'b0;
    drive(OP_IMM, 3'b001, 7'd0, 12'h001, 5'd1, 5'd0, 5'd16, 32'h77, 32'd0);
    step();
    in_valid = 1'b0;
    chk("rst1.one_valid", 64'(out_valid), 64'd1);
    rst = 1'b1;
    #1;
    chk("rst1.in_ready", 64'(in_ready), 64'd0);
    check_zero_outputs("rst1_during");
    step();
    rst = 1'b0; out_ready = 1'b1;
    #1;
    check_zero_outputs("rst1_after");
    chk("rst1.ready_after", 64'(in_ready), 64'd1);
    step();
    chk("rst1.no_ghost", 64'(out_valid), 64'd0);

    // x0 never forwarded
    fwd_valid = 1'b1; fwd_rd = 5'd0; fwd_data = 32'hDEAD;
    drive(OP_REG, 3'b001, 7'd0, 12'd0, 5'd0, 5'd0, 5'd17, 32'h1234, 32'h7);
    step();
    in_valid = 1'b0; fwd_valid = 1'b0;
    chk("x0.Src1", 64'(Src1), 64'h1234);
    chk("x0.Src2", 64'(Src2), 64'd7);
    chk("x0.flags", 64'({funct3_2, funct7_5, En, illegal}), 64'b0010);
    step();
    chk("x0.drain", 64'(out_valid), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
